// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : scan_decoder
//  Description : Registered multi-channel SEL_W-to-2^SEL_W decoder with
//                active-low enables and active-low one-hot outputs. A scan
//                mode sweeps every enabled channel through all outputs using
//                a prescaled shared index.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_decoder #(
    parameter int SEL_W = 2,
    parameter int CH    = 2,
    parameter int DIV_W = 8
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic [CH-1:0]               G_N,
    input  logic                        MODE,
    input  logic [CH*SEL_W-1:0]         SEL,
    input  logic [DIV_W-1:0]            DIV,
    output logic [CH*(2**SEL_W)-1:0]    Y_N,
    output logic [SEL_W-1:0]            SCAN_IDX,
    output logic                        WRAP
);

    localparam int              NOUT    = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] IDX_MAX = '1;

    logic [CH*NOUT-1:0] y_n_d;
    logic [CH*NOUT-1:0] y_n_q;
    logic [SEL_W-1:0]   scan_idx_d;
    logic [SEL_W-1:0]   scan_idx_q;
    logic [DIV_W-1:0]   count_d;
    logic [DIV_W-1:0]   count_q;
    logic               wrap_d;
    logic               wrap_q;

    // Per-channel decode. In scan mode the registered index is the source, so
    // the outputs trail SCAN_IDX by one cycle.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [SEL_W-1:0] src;
        logic [NOUT-1:0]  dec;

        assign src = MODE ? scan_idx_q : SEL[c*SEL_W +: SEL_W];

        // Active-low one-hot decode, forced all-high when the channel is disabled
        always_comb begin
            dec = '1;
            if (!G_N[c]) begin
                dec[src] = 1'b0;
            end
        end

        assign y_n_d[c*NOUT +: NOUT] = dec;
    end

    // Prescaler and scan index. The >= compare lets a lowered DIV force an
    // immediate step; leaving scan mode clears everything so the next scan
    // begins at index 0 with a full first period.
    always_comb begin
        count_d    = count_q;
        scan_idx_d = scan_idx_q;
        wrap_d     = 1'b0;
        if (MODE) begin
            if (count_q >= DIV) begin
                count_d    = '0;
                scan_idx_d = scan_idx_q + 1'b1;
                wrap_d     = (scan_idx_q == IDX_MAX);
            end else begin
                count_d    = count_q + 1'b1;
            end
        end else begin
            count_d    = '0;
            scan_idx_d = '0;
        end
    end

    // Output and counter registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            y_n_q      <= '1;
            scan_idx_q <= '0;
            count_q    <= '0;
            wrap_q     <= 1'b0;
        end else begin
            y_n_q      <= y_n_d;
            scan_idx_q <= scan_idx_d;
            count_q    <= count_d;
            wrap_q     <= wrap_d;
        end
    end

    assign Y_N      = y_n_q;
    assign SCAN_IDX = scan_idx_q;
    assign WRAP     = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_decoder
//  Description : Scoreboard bench for scan_decoder (default parameters) plus
//                a free-running scan check of a SEL_W=3, CH=4 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_decoder;

    localparam int SEL_W = 2;
    localparam int CH    = 2;
    localparam int DIV_W = 8;
    localparam int NOUT  = 4;
    localparam int YW    = CH * NOUT;

    logic               CLK = 1'b0;
    logic               RESET_N;
    logic [CH-1:0]      G_N;
    logic               MODE;
    logic [CH*SEL_W-1:0] SEL;
    logic [DIV_W-1:0]   DIV;
    logic [YW-1:0]      Y_N;
    logic [SEL_W-1:0]   SCAN_IDX;
    logic               WRAP;

    // Wider instance: SEL_W=3, CH=4
    logic               rst8_n;
    logic [3:0]         g8;
    logic               mode8;
    logic [11:0]        sel8;
    logic [3:0]         div8;
    logic [31:0]        y8;
    logic [2:0]         idx8;
    logic               wrap8;

    int checks = 0;
    int errors = 0;
    int m_cnt  = 0;
    int m_idx  = 0;
    bit sweep_done = 0;

    typedef struct {
        logic [YW-1:0]    y;
        logic [SEL_W-1:0] idx;
        logic             wrap;
    } exp_t;

    exp_t exp_q[$];

    scan_decoder #(.SEL_W(SEL_W), .CH(CH), .DIV_W(DIV_W)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .G_N(G_N), .MODE(MODE), .SEL(SEL),
        .DIV(DIV), .Y_N(Y_N), .SCAN_IDX(SCAN_IDX), .WRAP(WRAP)
    );

    scan_decoder #(.SEL_W(3), .CH(4), .DIV_W(4)) u_dut8 (
        .CLK(CLK), .RESET_N(rst8_n), .G_N(g8), .MODE(mode8), .SEL(sel8),
        .DIV(div8), .Y_N(y8), .SCAN_IDX(idx8), .WRAP(wrap8)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: one clock edge of the spec rules, expectation queued
    task automatic model_step(input logic [CH-1:0] g, input logic mode,
                              input logic [CH*SEL_W-1:0] sel, input int div);
        exp_t e;
        int   src;
        int   s;
        s   = int'(sel);
        e.y = '1;
        for (int c = 0; c < CH; c++) begin
            src = mode ? m_idx : (s >> (c * SEL_W)) % NOUT;
            if (!g[c]) e.y[c*NOUT + src] = 1'b0;
        end
        e.wrap = 1'b0;
        if (mode) begin
            if (m_cnt >= div) begin
                m_cnt  = 0;
                e.wrap = (m_idx == NOUT - 1);
                m_idx  = (m_idx + 1) % NOUT;
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0;
            m_idx = 0;
        end
        e.idx = m_idx[SEL_W-1:0];
        exp_q.push_back(e);
    endtask

    task automatic push_reset_exp();
        exp_t e;
        e.y = '1; e.idx = '0; e.wrap = 1'b0;
        m_cnt = 0; m_idx = 0;
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic [CH-1:0] g, input logic mode,
                         input logic [CH*SEL_W-1:0] sel, input int div);
        G_N = g; MODE = mode; SEL = sel; DIV = div[DIV_W-1:0];
        model_step(g, mode, sel, div);
    endtask

    task automatic drive(input logic [CH-1:0] g, input logic mode,
                         input logic [CH*SEL_W-1:0] sel, input int div);
        @(posedge CLK); #2;
        apply(g, mode, sel, div);
    endtask

    // Monitor: compare every registered output update against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK); #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("y_n", 64'(Y_N), 64'(e.y));
                chk("scan_idx", 64'(SCAN_IDX), 64'(e.idx));
                chk("wrap", 64'(WRAP), 64'(e.wrap));
            end
        end
    end

    // Wide instance: DIV=1, all channels enabled, continuous scan
    initial begin
        logic [31:0] ey;
        int p;
        int wraps;
        wraps = 0;
        rst8_n = 1'b0; g8 = '0; mode8 = 1'b1; sel8 = '0; div8 = 4'd1;
        @(posedge CLK); #1;
        chk("w8_reset_y", 64'(y8), 64'hFFFF_FFFF);
        chk("w8_reset_idx", 64'(idx8), 64'd0);
        @(posedge CLK); #2;
        rst8_n = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            @(posedge CLK); #1;
            p  = ((k - 1) / 2) % 8;
            ey = '1;
            for (int c = 0; c < 4; c++) ey[c*8 + p] = 1'b0;
            chk("w8_y", 64'(y8), 64'(ey));
            chk("w8_idx", 64'(idx8), 64'((k / 2) % 8));
            chk("w8_wrap", 64'(wrap8), 64'((k % 16) == 0));
            if (wrap8) wraps++;
        end
        chk("w8_wrap_count", 64'(wraps), 64'd3);
        sweep_done = 1;
    end

    // Stimulus
    initial begin
        int guard;
        RESET_N = 1'b0; G_N = '0; MODE = 1'b0; SEL = '0; DIV = '0;
        repeat (3) begin
            @(posedge CLK); #2;
            push_reset_exp();
        end
        @(posedge CLK); #2;
        RESET_N = 1'b1;

        // Direct decode with defaults, then disable channel 1
        apply(2'b00, 1'b0, {2'd3, 2'd1}, 0);
        drive(2'b00, 1'b0, {2'd3, 2'd1}, 0);
        chk("direct_lit", 64'(Y_N), 64'(8'b0111_1101));
        drive(2'b10, 1'b0, {2'd3, 2'd1}, 0);
        drive(2'b10, 1'b0, {2'd3, 2'd1}, 0);
        chk("direct_gn_lit", 64'(Y_N), 64'(8'b1111_1101));

        // Exhaustive direct decode
        for (int g = 0; g < 4; g++)
            for (int s = 0; s < 16; s++)
                drive(g[1:0], 1'b0, s[3:0], 0);

        // Scan, DIV=0
        for (int i = 0; i < 12; i++) drive(2'b00, 1'b1, '0, 0);
        drive(2'b00, 1'b0, '0, 0);

        // Scan, DIV=3, then drop DIV to 0 when count reaches 2
        for (int i = 0; i < 9; i++) drive(2'b00, 1'b1, '0, 3);
        guard = 0;
        while (m_cnt != 2 && guard < 8) begin
            drive(2'b00, 1'b1, '0, 3);
            guard++;
        end
        chk("div3_count_reached", 64'(m_cnt), 64'd2);
        drive(2'b00, 1'b1, '0, 0);
        drive(2'b01, 1'b1, '0, 0);
        drive(2'b00, 1'b0, {2'd2, 2'd0}, 0);
        drive(2'b00, 1'b0, {2'd2, 2'd0}, 0);

        // Mid-scan asynchronous reset with SCAN_IDX = 2
        guard = 0;
        drive(2'b00, 1'b1, '0, 1);
        while (m_idx != 2 && guard < 20) begin
            drive(2'b00, 1'b1, '0, 1);
            guard++;
        end
        @(posedge CLK); #3;
        chk("pre_reset_idx", 64'(SCAN_IDX), 64'd2);
        RESET_N = 1'b0;
        #1;
        chk("async_rst_y", 64'(Y_N), 64'hFF);
        chk("async_rst_idx", 64'(SCAN_IDX), 64'd0);
        chk("async_rst_wrap", 64'(WRAP), 64'd0);
        exp_q.delete();
        repeat (2) begin
            @(posedge CLK); #2;
            push_reset_exp();
        end
        @(posedge CLK); #2;
        RESET_N = 1'b1;
        apply(2'b00, 1'b1, '0, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [CH-1:0]       rg;
            logic                rm;
            logic [CH*SEL_W-1:0] rs;
            rg = CH'($urandom_range(0, 3));
            rm = ($urandom_range(0, 3) != 0);
            rs = (CH*SEL_W)'($urandom_range(0, 15));
            drive(rg, rm, rs, int'($urandom_range(0, 5)));
        end

        guard = 0;
        while ((exp_q.size() != 0 || !sweep_done) && guard < 200) begin
            @(posedge CLK);
            guard++;
        end
        chk("drain_timeout", 64'(guard >= 200), 64'd0);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
